// File: rtl/hand_datapath_pkg.sv
// Card code constants and value/score helpers shared by the card registers
// and the top-level score arithmetic for both hands.
package hand_datapath_pkg;

   localparam logic [3:0] CARD_EMPTY = 4'd0;
   localparam logic [3:0] CARD_MIN   = 4'd1;
   localparam logic [3:0] CARD_MAX   = 4'd13;
   localparam logic [3:0] FACE_MIN   = 4'd10;

   function automatic logic card_legal(input logic [3:0] code);
      return (code >= CARD_MIN) && (code <= CARD_MAX);
   endfunction

   // Empty slots and tens/face cards both count as zero.
   function automatic logic [3:0] card_value(input logic [3:0] code);
      if ((code == CARD_EMPTY) || (code >= FACE_MIN))
         return 4'd0;
      else
         return code;
   endfunction

   // The sum of three values reaches 27, so it is kept 5 bits wide before the mod-10 step.
   function automatic logic [3:0] hand_score(input logic [3:0] c1,
                                             input logic [3:0] c2,
                                             input logic [3:0] c3);
      logic [4:0] sum;
      logic [4:0] rem;
      sum = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
      rem = sum % 5'd10;
      return rem[3:0];
   endfunction

endpackage

// File: rtl/hand_datapath_card_reg.sv
// One card slot: loads new_card on its strobe, storing empty for illegal codes.
module card_reg
   import hand_datapath_pkg::*;
(
   input  logic       slow_clock,
   input  logic       resetb,
   input  logic       load,
   input  logic [3:0] new_card,
   output logic [3:0] card,
   output logic       illegal
);

   assign illegal = load & ~card_legal(new_card);

   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb)
         card <= CARD_EMPTY;
      else if (load)
         card <= card_legal(new_card) ? new_card : CARD_EMPTY;
   end

endmodule

// File: rtl/hand_datapath.sv
// Baccarat hand datapath: six card slots, combinational hand scores and a
// sticky illegal-load flag. Load sequencing is owned by the consumer.
module hand_datapath
   import hand_datapath_pkg::*;
(
   input  logic       slow_clock,
   input  logic       resetb,
   input  logic [3:0] new_card,
   input  logic       load_pcard1,
   input  logic       load_pcard2,
   input  logic       load_pcard3,
   input  logic       load_dcard1,
   input  logic       load_dcard2,
   input  logic       load_dcard3,
   output logic [3:0] pcard1_out,
   output logic [3:0] pcard2_out,
   output logic [3:0] pcard3_out,
   output logic [3:0] dcard1_out,
   output logic [3:0] dcard2_out,
   output logic [3:0] dcard3_out,
   output logic [3:0] pscore,
   output logic [3:0] dscore,
   output logic [3:0] pcard3,
   output logic       card_err,
   output logic       hand_full
);

   // Slot order: player 1..3, then dealer 1..3.
   logic [5:0] load;
   logic [5:0] illegal;
   logic [3:0] cards [6];

   assign load = {load_dcard3, load_dcard2, load_dcard1,
                  load_pcard3, load_pcard2, load_pcard1};

   for (genvar i = 0; i < 6; i++) begin : g_slot
      card_reg u_card_reg (
         .slow_clock (slow_clock),
         .resetb     (resetb),
         .load       (load[i]),
         .new_card   (new_card),
         .card       (cards[i]),
         .illegal    (illegal[i])
      );
   end

   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb)
         card_err <= 1'b0;
      else if (|illegal)
         card_err <= 1'b1;
   end

   assign pcard1_out = cards[0];
   assign pcard2_out = cards[1];
   assign pcard3_out = cards[2];
   assign dcard1_out = cards[3];
   assign dcard2_out = cards[4];
   assign dcard3_out = cards[5];

   assign pscore = hand_score(cards[0], cards[1], cards[2]);
   assign dscore = hand_score(cards[3], cards[4], cards[5]);
   assign pcard3 = card_value(cards[2]);

   assign hand_full = (cards[0] != CARD_EMPTY) && (cards[1] != CARD_EMPTY) &&
                      (cards[2] != CARD_EMPTY) && (cards[3] != CARD_EMPTY) &&
                      (cards[4] != CARD_EMPTY) && (cards[5] != CARD_EMPTY);

endmodule

// File: tb/tb_hand_datapath.sv
// Directed bench for hand_datapath: a reference model pushes the expected
// output snapshot per load step; it is popped and compared after the edge.
module tb_hand_datapath;

   typedef struct packed {
      logic [23:0] cards;   // {d3,d2,d1,p3,p2,p1}
      logic [3:0]  ps;
      logic [3:0]  ds;
      logic [3:0]  p3;
      logic        err;
      logic        full;
   } snap_t;

   logic       slow_clock;
   logic       resetb;
   logic [3:0] new_card;
   logic       load_pcard1, load_pcard2, load_pcard3;
   logic       load_dcard1, load_dcard2, load_dcard3;
   logic [3:0] pcard1_out, pcard2_out, pcard3_out;
   logic [3:0] dcard1_out, dcard2_out, dcard3_out;
   logic [3:0] pscore, dscore, pcard3;
   logic       card_err, hand_full;

   int total = 0;
   int bad   = 0;

   logic [3:0] m_card [6];
   logic       m_err;
   snap_t      sb_q [$];

   hand_datapath dut (
      .slow_clock  (slow_clock),
      .resetb      (resetb),
      .new_card    (new_card),
      .load_pcard1 (load_pcard1),
      .load_pcard2 (load_pcard2),
      .load_pcard3 (load_pcard3),
      .load_dcard1 (load_dcard1),
      .load_dcard2 (load_dcard2),
      .load_dcard3 (load_dcard3),
      .pcard1_out  (pcard1_out),
      .pcard2_out  (pcard2_out),
      .pcard3_out  (pcard3_out),
      .dcard1_out  (dcard1_out),
      .dcard2_out  (dcard2_out),
      .dcard3_out  (dcard3_out),
      .pscore      (pscore),
      .dscore      (dscore),
      .pcard3      (pcard3),
      .card_err    (card_err),
      .hand_full   (hand_full)
   );

   initial slow_clock = 1'b0;
   always #5 slow_clock = ~slow_clock;

   function automatic logic [3:0] ref_val(input logic [3:0] c);
      return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
   endfunction

   function automatic snap_t model_snap();
      snap_t s;
      int    psum, dsum;
      psum = ref_val(m_card[0]) + ref_val(m_card[1]) + ref_val(m_card[2]);
      dsum = ref_val(m_card[3]) + ref_val(m_card[4]) + ref_val(m_card[5]);
      s.cards = {m_card[5], m_card[4], m_card[3], m_card[2], m_card[1], m_card[0]};
      s.ps    = 4'(psum % 10);
      s.ds    = 4'(dsum % 10);
      s.p3    = ref_val(m_card[2]);
      s.err   = m_err;
      s.full  = (m_card[0] != 0) && (m_card[1] != 0) && (m_card[2] != 0) &&
                (m_card[3] != 0) && (m_card[4] != 0) && (m_card[5] != 0);
      return s;
   endfunction

   function automatic snap_t dut_snap();
      snap_t s;
      s.cards = {dcard3_out, dcard2_out, dcard1_out, pcard3_out, pcard2_out, pcard1_out};
      s.ps    = pscore;
      s.ds    = dscore;
      s.p3    = pcard3;
      s.err   = card_err;
      s.full  = hand_full;
      return s;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 6; i++) m_card[i] = 4'd0;
      m_err = 1'b0;
   endtask

   // Drive strobes at the falling edge, push the expectation, then pop and
   // compare one time unit after the loading edge.
   task automatic step(input string tag, input logic [5:0] ld, input logic [3:0] nc);
      snap_t e;
      @(negedge slow_clock);
      new_card = nc;
      {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = ld;
      if (resetb) begin
         for (int i = 0; i < 6; i++)
            if (ld[i]) m_card[i] = (nc >= 4'd1 && nc <= 4'd13) ? nc : 4'd0;
         if ((ld != 6'd0) && !(nc >= 4'd1 && nc <= 4'd13)) m_err = 1'b1;
      end
      sb_q.push_back(model_snap());
      @(posedge slow_clock);
      #1;
      if (sb_q.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s: observed=empty scoreboard expected=entry", tag);
      end else begin
         e = sb_q.pop_front();
         check(tag, 64'(dut_snap()), 64'(e));
      end
      @(negedge slow_clock);
      {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = 6'd0;
   endtask

   task automatic do_reset();
      @(negedge slow_clock);
      resetb = 1'b0;
      model_clear();
      #1;
      check("reset_clear", 64'(dut_snap()), 64'(model_snap()));
      #2;
      resetb = 1'b1;
   endtask

   initial begin
      resetb   = 1'b0;
      new_card = 4'd0;
      {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = 6'd0;
      model_clear();

      // Random strobes and codes while held in reset: everything stays 0.
      for (int k = 0; k < 3; k++)
         step("reset_rand", 6'($urandom_range(1, 63)), 4'($urandom_range(0, 15)));
      check("reset_pscore", 64'(pscore), 64'd0);
      @(negedge slow_clock);
      resetb = 1'b1;

      step("p1_7", 6'b000001, 4'd7);
      check("p1_7_out", 64'(pcard1_out), 64'd7);
      check("p1_7_score", 64'(pscore), 64'd7);

      step("p1_9", 6'b000001, 4'd9);
      step("p2_8", 6'b000010, 4'd8);
      step("p3_7", 6'b000100, 4'd7);
      check("mod10_pscore", 64'(pscore), 64'd4);
      check("mod10_pcard3", 64'(pcard3), 64'd7);
      step("d1_13", 6'b001000, 4'd13);
      step("d2_5", 6'b010000, 4'd5);
      step("d3_6", 6'b100000, 4'd6);
      check("mod10_dscore", 64'(dscore), 64'd1);
      check("full_after_six", 64'(hand_full), 64'd1);

      do_reset();
      step("p1_10", 6'b000001, 4'd10);
      step("p2_12", 6'b000010, 4'd12);
      check("face_pscore", 64'(pscore), 64'd0);
      check("face_p2_out", 64'(pcard2_out), 64'd12);
      step("p3_11", 6'b000100, 4'd11);
      check("face_pcard3", 64'(pcard3), 64'd0);
      check("face_p3_out", 64'(pcard3_out), 64'd11);

      step("d1_15", 6'b001000, 4'd15);
      check("illegal_d1_out", 64'(dcard1_out), 64'd0);
      check("illegal_err", 64'(card_err), 64'd1);
      step("d2_3", 6'b010000, 4'd3);
      step("d1_13_legal", 6'b001000, 4'd13);
      check("err_sticky", 64'(card_err), 64'd1);
      do_reset();
      check("err_cleared", 64'(card_err), 64'd0);

      // Boundary codes: 0 and 14 illegal, 1 and 13 legal.
      step("p1_1", 6'b000001, 4'd1);
      check("legal_1_err", 64'(card_err), 64'd0);
      step("p2_13", 6'b000010, 4'd13);
      check("legal_13_err", 64'(card_err), 64'd0);
      step("p3_0", 6'b000100, 4'd0);
      check("code0_err", 64'(card_err), 64'd1);
      do_reset();
      step("d3_14", 6'b100000, 4'd14);
      check("code14_err", 64'(card_err), 64'd1);
      step("hold", 6'b000000, 4'd9);
      do_reset();

      step("all_4", 6'b111111, 4'd4);
      check("all_cards", 64'(dut_snap().cards), 64'h444444);
      check("all_pscore", 64'(pscore), 64'd2);
      check("all_dscore", 64'(dscore), 64'd2);
      check("all_full", 64'(hand_full), 64'd1);

      do_reset();
      step("mh_p1", 6'b000001, 4'd5);
      step("mh_p2", 6'b000010, 4'd3);
      step("mh_d1", 6'b001000, 4'd9);
      step("mh_d2", 6'b010000, 4'd2);
      do_reset();
      check("mh_cleared_cards", 64'(dut_snap().cards), 64'd0);
      step("mh_p1_6", 6'b000001, 4'd6);
      check("mh_pscore", 64'(pscore), 64'd6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=no finish expected=finish");
      $fatal(1, "timeout");
   end

endmodule
